// File: rtl/subterranean_seq_pkg.sv
// Shared state encodings and helpers for the Subterranean-SAE duplex sequencer.
package subterranean_seq_pkg;

    typedef logic [3:0] seq_state_t;

    localparam seq_state_t ST_IDLE   = 4'd0;
    localparam seq_state_t ST_INIT   = 4'd1;
    localparam seq_state_t ST_KEY    = 4'd2;
    localparam seq_state_t ST_NONCE  = 4'd3;
    localparam seq_state_t ST_BLANK1 = 4'd4;
    localparam seq_state_t ST_AD     = 4'd5;
    localparam seq_state_t ST_MSG    = 4'd6;
    localparam seq_state_t ST_BLANK2 = 4'd7;
    localparam seq_state_t ST_TAG    = 4'd8;
    localparam seq_state_t ST_DONE   = 4'd9;

    localparam int KEY_BYTES   = 16;
    localparam int NONCE_BYTES = 16;

    // Bytes absorbed by one duplex call: a full word, or whatever tail is left.
    function automatic logic [2:0] call_size(input logic ge4, input logic [2:0] rem_low);
        if (ge4) begin
            return 3'd4;
        end else begin
            return rem_low;
        end
    endfunction

endpackage

// File: rtl/subterranean_seq_phase_cnt.sv
// Remaining-byte counter for one absorb phase; reloaded at each phase boundary.
module subterranean_seq_phase_cnt #(
    parameter int LEN_W = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [2:0]       size_o,
    output logic             last_o,
    output logic             extra_empty_o,
    output logic             last_data_o
);
    import subterranean_seq_pkg::*;

    logic [LEN_W-1:0] rem_q, rem_d;
    logic             ge4_s;

    assign ge4_s         = (rem_q >= LEN_W'(4));
    assign size_o        = call_size(ge4_s, rem_q[2:0]);
    assign last_o        = ~ge4_s;
    assign extra_empty_o = (rem_q == '0);
    // Final call that still carries data (the one before a size-0 terminator, or the tail).
    assign last_data_o   = ~extra_empty_o & (rem_q <= LEN_W'(4));

    // Saturating decrement by one word per issued call.
    always_comb begin
        rem_d = rem_q;
        if (load_i) begin
            rem_d = len_i;
        end else if (step_i) begin
            rem_d = ge4_s ? (rem_q - LEN_W'(4)) : '0;
        end else begin
            rem_d = rem_q;
        end
    end

    // Remaining-length register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/subterranean_aead_sequencer.sv
// Drives one Subterranean duplex core through a complete SAE encrypt/decrypt operation.
module subterranean_aead_sequencer #(
    parameter int LEN_W        = 16,
    parameter int BLANK_ROUNDS = 8,
    parameter int TAG_WORDS    = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_decrypt,
    input  logic [LEN_W-1:0] cmd_ad_len,
    input  logic [LEN_W-1:0] cmd_msg_len,
    input  logic [31:0]      s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [31:0]      m_tdata,
    output logic [2:0]       m_tbytes,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             sts_valid,
    output logic             sts_tag_ok,
    output logic             core_init,
    output logic             core_start,
    output logic             core_encrypt,
    output logic             core_decrypt,
    output logic [31:0]      core_din,
    output logic [2:0]       core_din_size,
    input  logic [31:0]      core_dout,
    input  logic             core_free,
    input  logic             core_finish
);
    import subterranean_seq_pkg::*;

    localparam logic [7:0] BLANK_LAST = 8'(BLANK_ROUNDS - 1);
    localparam logic [7:0] TAG_LAST   = 8'(TAG_WORDS - 1);

    seq_state_t       state_q, state_d, next_phase_s;
    logic             decrypt_q, waiting_q, tag_ok_q;
    logic [LEN_W-1:0] ad_len_q, msg_len_q, next_len_s;
    logic [7:0]       rnd_q, rnd_d;
    logic             pend_out_q, pend_last_q, pend_cmp_q;
    logic [2:0]       pend_bytes_q;
    logic [31:0]      tag_word_q;

    logic             cmd_ready_q, s_tready_q, m_tvalid_q, m_tlast_q, sts_valid_q, sts_tag_ok_q;
    logic             core_init_q, core_start_q, core_encrypt_q, core_decrypt_q;
    logic [31:0]      m_tdata_q, core_din_q;
    logic [2:0]       m_tbytes_q, core_din_size_q;

    logic [2:0]       cnt_size_s;
    logic             cnt_last_s, cnt_extra_s, cnt_last_data_s, cnt_load_s;
    logic             counted_s, consumes_s, produces_s, phase_last_s, in_call_s;
    logic             issue_s, done_ok_s, cmd_fire_s, capture_s;

    subterranean_seq_phase_cnt #(.LEN_W(LEN_W)) u_phase_cnt (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .load_i        (cnt_load_s),
        .step_i        (issue_s),
        .len_i         (next_len_s),
        .size_o        (cnt_size_s),
        .last_o        (cnt_last_s),
        .extra_empty_o (cnt_extra_s),
        .last_data_o   (cnt_last_data_s)
    );

    // Call gating: a call needs an idle core, input data if it consumes, and room if it produces.
    always_comb begin
        counted_s  = (state_q == ST_KEY) || (state_q == ST_NONCE) ||
                     (state_q == ST_AD)  || (state_q == ST_MSG);
        in_call_s  = (state_q != ST_IDLE) && (state_q != ST_DONE);
        consumes_s = (counted_s && !cnt_extra_s) || ((state_q == ST_TAG) && decrypt_q);
        produces_s = ((state_q == ST_MSG) && !cnt_extra_s) || ((state_q == ST_TAG) && !decrypt_q);
        case (state_q)
            ST_INIT:                            phase_last_s = 1'b1;
            ST_KEY, ST_NONCE, ST_AD, ST_MSG:    phase_last_s = cnt_last_s;
            ST_BLANK1, ST_BLANK2:               phase_last_s = (rnd_q == BLANK_LAST);
            ST_TAG:                             phase_last_s = (rnd_q == TAG_LAST);
            default:                            phase_last_s = 1'b0;
        endcase
        issue_s    = in_call_s && !waiting_q && core_free &&
                     (!consumes_s || s_tvalid) && (!produces_s || !m_tvalid_q || m_tready);
        done_ok_s  = (state_q == ST_DONE) && !waiting_q && !m_tvalid_q;
        cmd_fire_s = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
        capture_s  = waiting_q && core_finish;
    end

    // Phase order and the byte length each counted phase starts from.
    always_comb begin
        next_len_s = '0;
        case (state_q)
            ST_INIT:   begin next_phase_s = ST_KEY;    next_len_s = LEN_W'(KEY_BYTES);   end
            ST_KEY:    begin next_phase_s = ST_NONCE;  next_len_s = LEN_W'(NONCE_BYTES); end
            ST_NONCE:  begin next_phase_s = ST_BLANK1; end
            ST_BLANK1: begin next_phase_s = ST_AD;     next_len_s = ad_len_q;            end
            ST_AD:     begin next_phase_s = ST_MSG;    next_len_s = msg_len_q;           end
            ST_MSG:    begin next_phase_s = ST_BLANK2; end
            ST_BLANK2: begin next_phase_s = ST_TAG;    end
            ST_TAG:    begin next_phase_s = ST_DONE;   end
            default:   begin next_phase_s = ST_IDLE;   end
        endcase
        cnt_load_s = issue_s && phase_last_s;
        state_d    = state_q;
        rnd_d      = rnd_q;
        if (cmd_fire_s) begin
            state_d = ST_INIT;
        end else if (done_ok_s) begin
            state_d = ST_IDLE;
        end else if (issue_s) begin
            state_d = phase_last_s ? next_phase_s : state_q;
            rnd_d   = phase_last_s ? 8'd0 : (rnd_q + 8'd1);
        end else begin
            state_d = state_q;
        end
    end

    // Sequencer state, command latch and the registered core request.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= ST_IDLE;
            rnd_q           <= 8'd0;
            cmd_ready_q     <= 1'b0;
            decrypt_q       <= 1'b0;
            ad_len_q        <= '0;
            msg_len_q       <= '0;
            waiting_q       <= 1'b0;
            pend_out_q      <= 1'b0;
            pend_last_q     <= 1'b0;
            pend_cmp_q      <= 1'b0;
            pend_bytes_q    <= 3'd0;
            tag_word_q      <= 32'd0;
            s_tready_q      <= 1'b0;
            core_start_q    <= 1'b0;
            core_init_q     <= 1'b0;
            core_encrypt_q  <= 1'b0;
            core_decrypt_q  <= 1'b0;
            core_din_q      <= 32'd0;
            core_din_size_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            if (cmd_fire_s) begin
                decrypt_q <= cmd_decrypt;
                ad_len_q  <= cmd_ad_len;
                msg_len_q <= cmd_msg_len;
            end
            core_start_q    <= issue_s;
            core_init_q     <= issue_s && (state_q == ST_INIT);
            core_encrypt_q  <= issue_s && (state_q == ST_MSG) && !decrypt_q;
            core_decrypt_q  <= issue_s && (state_q == ST_MSG) && decrypt_q;
            core_din_size_q <= (issue_s && counted_s) ? cnt_size_s : 3'd0;
            core_din_q      <= (issue_s && counted_s && !cnt_extra_s) ? s_tdata : 32'd0;
            s_tready_q      <= issue_s && consumes_s;
            if (issue_s) begin
                waiting_q    <= 1'b1;
                pend_out_q   <= produces_s;
                pend_bytes_q <= (state_q == ST_MSG) ? cnt_size_s : 3'd4;
                pend_last_q  <= ((state_q == ST_TAG) && !decrypt_q && phase_last_s) ||
                                ((state_q == ST_MSG) && decrypt_q && cnt_last_data_s);
                pend_cmp_q   <= (state_q == ST_TAG) && decrypt_q;
                tag_word_q   <= s_tdata;
            end else if (core_finish) begin
                waiting_q <= 1'b0;
            end
        end
    end

    // Single-entry output register, tag comparison and completion status.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            m_tdata_q    <= 32'd0;
            m_tbytes_q   <= 3'd0;
            tag_ok_q     <= 1'b0;
            sts_valid_q  <= 1'b0;
            sts_tag_ok_q <= 1'b0;
        end else begin
            if (capture_s && pend_out_q) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= core_dout;
                m_tbytes_q <= pend_bytes_q;
                m_tlast_q  <= pend_last_q;
            end else if (m_tvalid_q && m_tready) begin
                m_tvalid_q <= 1'b0;
                m_tlast_q  <= 1'b0;
            end
            if (cmd_fire_s) begin
                tag_ok_q <= 1'b1;
            end else if (capture_s && pend_cmp_q && (core_dout != tag_word_q)) begin
                tag_ok_q <= 1'b0;
            end
            sts_valid_q  <= done_ok_s;
            sts_tag_ok_q <= done_ok_s && tag_ok_q;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign s_tready      = s_tready_q;
    assign m_tdata       = m_tdata_q;
    assign m_tbytes      = m_tbytes_q;
    assign m_tvalid      = m_tvalid_q;
    assign m_tlast       = m_tlast_q;
    assign sts_valid     = sts_valid_q;
    assign sts_tag_ok    = sts_tag_ok_q;
    assign core_init     = core_init_q;
    assign core_start    = core_start_q;
    assign core_encrypt  = core_encrypt_q;
    assign core_decrypt  = core_decrypt_q;
    assign core_din      = core_din_q;
    assign core_din_size = core_din_size_q;

endmodule

// File: tb/tb_subterranean_aead_sequencer.sv
// Scoreboard bench for subterranean_aead_sequencer with a one-cycle-latency core model.
module tb_subterranean_aead_sequencer;

    logic        aclk, aresetn;
    logic        cmd_valid, cmd_ready, cmd_decrypt;
    logic [15:0] cmd_ad_len, cmd_msg_len;
    logic [31:0] s_tdata, m_tdata, core_din, core_dout;
    logic        s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
    logic [2:0]  m_tbytes, core_din_size;
    logic        sts_valid, sts_tag_ok;
    logic        core_init, core_start, core_encrypt, core_decrypt, core_free, core_finish;

    typedef struct packed {
        logic [2:0]  size;
        logic        init, enc, dec, consume, out, last;
        logic [31:0] din, dout;
    } call_t;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  bytes;
        logic        last;
    } out_t;

    call_t       exp_calls[$];
    out_t        exp_outs[$];
    logic [31:0] s_words[$];
    int          n_tests, n_fail;
    int          cidx;

    subterranean_aead_sequencer dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_decrypt(cmd_decrypt),
        .cmd_ad_len(cmd_ad_len), .cmd_msg_len(cmd_msg_len),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tbytes(m_tbytes), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .sts_valid(sts_valid), .sts_tag_ok(sts_tag_ok),
        .core_init(core_init), .core_start(core_start), .core_encrypt(core_encrypt),
        .core_decrypt(core_decrypt), .core_din(core_din), .core_din_size(core_din_size),
        .core_dout(core_dout), .core_free(core_free), .core_finish(core_finish)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    function automatic logic [31:0] mix(input int idx, input logic [31:0] d);
        return d ^ (32'h9E3779B9 * 32'(idx)) ^ 32'h0BADC0DE;
    endfunction

    // Core model: finish one cycle after start, busy only during that cycle.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            core_finish <= 1'b0;
            core_dout   <= 32'd0;
            cidx        <= 0;
        end else begin
            core_finish <= core_start;
            if (core_start) begin
                core_dout <= mix(core_init ? 0 : cidx, core_din);
                cidx      <= core_init ? 1 : cidx + 1;
            end
        end
    end
    assign core_free = ~core_finish;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_call(input logic [2:0] size, input logic init, input logic enc,
                             input logic dec, input logic consume, input logic out,
                             input logic last, input logic [31:0] din);
        call_t c;
        out_t  o;
        c = '{size: size, init: init, enc: enc, dec: dec, consume: consume, out: out,
              last: last, din: din, dout: mix(exp_calls.size(), din)};
        exp_calls.push_back(c);
        if (out) begin
            o = '{data: c.dout, bytes: (size == 3'd0) ? 3'd4 : size, last: last};
            exp_outs.push_back(o);
        end
    endtask

    task automatic push_phase(input int len, input logic is_msg, input logic dec);
        int          rem;
        logic [2:0]  sz;
        logic [31:0] w;
        rem = len;
        forever begin
            sz = (rem >= 4) ? 3'd4 : 3'(rem);
            w  = 32'd0;
            if (sz != 3'd0) begin
                w = $urandom;
                s_words.push_back(w);
            end
            push_call(sz, 1'b0, is_msg && !dec, is_msg && dec, sz != 3'd0,
                      is_msg && sz != 3'd0, is_msg && dec && sz != 3'd0 && rem <= 4, w);
            if (rem < 4) break;
            rem -= 4;
        end
    endtask

    task automatic build_op(input logic dec, input int ad, input int msg, input logic flip);
        logic [31:0] t;
        exp_calls.delete();
        exp_outs.delete();
        s_words.delete();
        push_call(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        push_phase(16, 1'b0, dec);
        push_phase(16, 1'b0, dec);
        for (int i = 0; i < 8; i++) push_call(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        push_phase(ad, 1'b0, dec);
        push_phase(msg, 1'b1, dec);
        for (int i = 0; i < 8; i++) push_call(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (dec) begin
                t = mix(exp_calls.size(), 32'd0) ^ ((flip && i == 1) ? 32'h0000_0100 : 32'd0);
                s_words.push_back(t);
                push_call(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
            end else begin
                push_call(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, i == 3, 32'd0);
            end
        end
    endtask

    // Runs one command; rdy_mode 0=always ready, 1=random, 2=stall window. abort_at>0 stops early.
    task automatic run_op(input logic dec, input int ad, input int msg, input logic flip,
                          input int rdy_mode, input int gap, input int exp_starts,
                          input int abort_at);
        int    n_starts, n_outs, n_exp_outs, cyc;
        logic  done, s_hs, cmd_acc;
        call_t c;
        out_t  o;
        build_op(dec, ad, msg, flip);
        n_exp_outs  = exp_outs.size();
        cmd_valid   = 1'b1;
        cmd_decrypt = dec;
        cmd_ad_len  = 16'(ad);
        cmd_msg_len = 16'(msg);
        n_starts = 0; n_outs = 0; cyc = 0; done = 1'b0; cmd_acc = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge aclk);
            if (core_start) begin
                n_starts++;
                check_val("core_free", core_free, 1);
                if (exp_calls.size() == 0) begin
                    check_val("start_count", n_starts, exp_starts);
                end else begin
                    c = exp_calls.pop_front();
                    check_val("call_flags", {core_din_size, core_init, core_encrypt, core_decrypt},
                              {c.size, c.init, c.enc, c.dec});
                    check_val("core_din", core_din, c.din);
                    check_val("s_tready", s_tready, c.consume);
                    if (c.consume) check_val("s_tvalid", s_tvalid, 1);
                    if (c.out) check_val("bp_start", m_tvalid & ~m_tready, 0);
                end
                if (abort_at > 0 && n_starts == abort_at) done = 1'b1;
            end
            if (s_tready && !core_start) check_val("s_tready_idle", s_tready, 0);
            if (m_tvalid && m_tready) begin
                n_outs++;
                if (exp_outs.size() == 0) begin
                    check_val("out_count", n_outs, n_exp_outs);
                end else begin
                    o = exp_outs.pop_front();
                    check_val("m_tdata", m_tdata, o.data);
                    check_val("m_tbytes_last", {m_tbytes, m_tlast}, {o.bytes, o.last});
                end
            end
            if (sts_valid && !done) begin
                check_val("sts_tag_ok", sts_tag_ok, !(dec && flip));
                check_val("starts", n_starts, exp_starts);
                check_val("calls_left", exp_calls.size(), 0);
                check_val("outs_left", exp_outs.size(), 0);
                done = 1'b1;
            end
            if (cmd_valid && cmd_ready) cmd_acc = 1'b1;
            s_hs = s_tvalid & s_tready;
            @(posedge aclk);
            #1;
            cyc++;
            if (cmd_acc) cmd_valid = 1'b0;
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ($urandom_range(0, 1) == 1);
                default: m_tready = !(cyc >= 65 && cyc < 85);
            endcase
            if (s_hs) void'(s_words.pop_front());
            if (!(s_tvalid && !s_hs)) begin
                if (s_words.size() > 0 && (gap == 0 || $urandom_range(0, 2) != 0)) begin
                    s_tvalid = 1'b1;
                    s_tdata  = s_words[0];
                end else begin
                    s_tvalid = 1'b0;
                    s_tdata  = 32'd0;
                end
            end
        end
        check_val("op_timeout", done, 1);
        m_tready = 1'b1;
        if (abort_at == 0) begin
            @(negedge aclk);
            check_val("sts_pulse_len", sts_valid, 0);
            check_val("cmd_ready_after", cmd_ready, 1);
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_val(tag, {cmd_ready, s_tready, m_tvalid, m_tlast, m_tbytes, sts_valid, sts_tag_ok,
                        core_init, core_start, core_encrypt, core_decrypt, core_din_size}, 16'd0);
        check_val({tag, "_data"}, {m_tdata, core_din}, 64'd0);
    endtask

    task automatic release_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check_val("cmd_ready_rel0", cmd_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check_val("cmd_ready_rel1", cmd_ready, 1);
            check_val("no_stale_sts", sts_valid, 0);
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        aresetn = 1'b0; cmd_valid = 1'b0; cmd_decrypt = 1'b0;
        cmd_ad_len = 16'd0; cmd_msg_len = 16'd0;
        s_tdata = 32'd0; s_tvalid = 1'b0; m_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outs("reset_outs");
        release_reset();

        run_op(1'b0, 0, 0, 1'b0, 0, 0, 33, 0);
        run_op(1'b0, 5, 7, 1'b0, 0, 0, 35, 0);
        run_op(1'b1, 0, 8, 1'b0, 0, 0, 35, 0);
        run_op(1'b1, 0, 8, 1'b1, 0, 0, 35, 0);
        run_op(1'b0, 0, 40, 1'b0, 2, 0, 43, 0);
        run_op(1'b1, 9, 13, 1'b0, 1, 1, 38, 0);
        run_op(1'b0, 3, 0, 1'b0, 0, 0, 0, 13);

        #2;
        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        s_tvalid  = 1'b0;
        #1;
        check_reset_outs("midop_reset_outs");
        repeat (2) @(posedge aclk);
        release_reset();
        run_op(1'b0, 4, 4, 1'b0, 1, 0, 35, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
